muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width (SHALL support 32 and 64).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  unit can accept; SHALL equal (state==IDLE).
REQ-006 funct3  in  3  RV32M/RV64M op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-007 rs1_data  in  XLEN  operand a.
REQ-008 rs2_data  in  XLEN  operand b.
REQ-009 flush  in  1  abandon any in-flight op.
REQ-010 out_valid  out  1  result present; SHALL equal (state==DONE).
REQ-011 out_ready  in  1  consumer takes result.
REQ-012 result  out  XLEN  op result; held stable while out_valid && !out_ready.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE.
REQ-014 Accept SHALL occur on an edge with state==IDLE, in_valid=1, flush=0; funct3 and operands SHALL be latched at that edge.
REQ-015 Normal ops: IDLE->CALC on accept; one radix-2 step per CALC cycle; CALC->DONE on the edge completing step XLEN; out_valid SHALL rise exactly XLEN cycles after the accept edge.
REQ-016 Multiply SHALL be shift-add over magnitudes producing a 2*XLEN product; MUL returns low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits.
REQ-017 Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned; DIV/REM signed; signed results SHALL be produced by negating the unsigned magnitude result (two's complement over the full product width).
REQ-018 Divide SHALL be restoring, quotient truncated toward zero, remainder sign = dividend sign.
REQ-019 Divide-by-zero (rs2==0): quotient all-ones, remainder = rs1; IDLE->DONE directly, out_valid one cycle after accept.
REQ-020 Signed overflow (DIV/REM, rs1 = most-negative, rs2 = -1): quotient = rs1, remainder = 0; IDLE->DONE, latency 1.
REQ-021 DONE->IDLE on edge with out_valid && out_ready; no accept on that same edge (in_ready low in DONE).
REQ-022 flush=1 SHALL force state to IDLE on the next edge from any state, discard the result, and block acceptance that edge; out_valid SHALL be 0 the following cycle.
REQ-023 Undefined funct3 values do not exist (3-bit space fully decoded); no error output.

Reset
REQ-024 reset SHALL take priority over flush and all handshakes.
REQ-025 After reset: state=IDLE, in_ready=1, out_valid=0, result=0, step counter=0, all datapath registers=0.
REQ-026 reset asserted mid-CALC or in DONE SHALL drop the op; no out_valid for it ever follows.

Structure
REQ-027 Shared package SHALL hold: R_TYPE opcode 7'b0110011, funct7 MULDIV 7'b0000001, funct3 enum for the eight M ops, FSM state enum.
REQ-028 Single module; no sub-module; step counter width $clog2(XLEN+1).

Verification (XLEN=32 unless stated)
REQ-029 MUL 3*2, then MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0x00000006, then 0xFFFFFFFE; out_valid exactly 32 cycles after each accept.
REQ-030 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, latency 1.
REQ-032 DIVU 0x12345678 / 0 -> 0xFFFFFFFF; REMU same -> 0x12345678; both latency 1.
REQ-033 flush at CALC cycle 10, then reset in CALC -> no out_valid; next accept completes correctly; out_ready held low 5 cycles in DONE -> result and out_valid stable.
REQ-034 XLEN=64: MULHU 0xFFFFFFFFFFFFFFFF squared -> 0xFFFFFFFFFFFFFFFE; out_valid 64 cycles after accept.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV M-extension multiply/divide unit.
package muldiv_pkg;

  localparam logic [6:0] OPC_R_TYPE    = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply (shift-add) / restoring divide for RV32M/RV64M.
// state | meaning: IDLE accept op | CALC one step per cycle | DONE hold result
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  funct3_e           op_q;
  logic              neg_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   res_q;

  funct3_e         f_in;
  logic            a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    f_in     = funct3_e'(funct3);
    a_signed = (f_in == F3_MULH) || (f_in == F3_MULHSU) || (f_in[2] && !f_in[0]);
    b_signed = (f_in == F3_MULH) || (f_in[2] && !f_in[0]);
    a_neg    = a_signed && rs1_data[XLEN-1];
    b_neg    = b_signed && rs2_data[XLEN-1];
    a_mag    = a_neg ? ('0 - rs1_data) : rs1_data;
    b_mag    = b_neg ? ('0 - rs2_data) : rs2_data;
    // remainder follows the dividend sign, everything else the sign product
    neg_in   = (f_in[2] && f_in[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = f_in[2] && (rs2_data == '0);
    div_ovf  = f_in[2] && !f_in[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
    fast_res = div_zero ? (f_in[1] ? rs1_data : '1)
                        : (f_in[1] ? '0 : rs1_data);
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_sel, div_res, res_d;

  // acc_q: multiply {partial hi, multiplier lo}; divide {remainder, quotient/dividend}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, b_q};
    div_ge    = !div_diff[XLEN];
    if (op_q[2])
      acc_d = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
               acc_q[XLEN-2:0], div_ge};
    else
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    prod    = neg_q ? ('0 - acc_d) : acc_d;
    div_sel = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
    div_res = neg_q ? ('0 - div_sel) : div_sel;
    if (op_q[2])
      res_d = div_res;
    else if (op_q == F3_MUL)
      res_d = prod[XLEN-1:0];
    else
      res_d = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= F3_MUL;
      neg_q   <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q <= f_in;
            if (div_zero || div_ovf) begin
              res_q   <= fast_res;
              state_q <= DONE;
            end else begin
              acc_q   <= {{XLEN{1'b0}}, a_mag};
              b_q     <= b_mag;
              neg_q   <= neg_in;
              cnt_q   <= CW'(XLEN);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            res_q   <= res_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table on a 32-bit instance plus
// flush/reset/back-pressure sequences and a 64-bit instance.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        iv32 = 1'b0, iv64 = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic        ir32, ov32, ir64, ov64;
  logic [31:0] res32;
  logic [63:0] res64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .funct3(funct3),
    .rs1_data(rs1[31:0]), .rs2_data(rs2[31:0]), .flush(flush),
    .out_valid(ov32), .out_ready(out_ready), .result(res32)
  );

  muldiv_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .funct3(funct3),
    .rs1_data(rs1), .rs2_data(rs2), .flush(flush),
    .out_valid(ov64), .out_ready(out_ready), .result(res64)
  );

  typedef struct {
    funct3_e     f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;   // edges from accept edge to out_valid rise
  } vec_t;

  vec_t vt[19];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic ov(input bit w);
    return w ? ov64 : ov32;
  endfunction

  task automatic run_op(input bit w, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] r, output int n);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b;
    check("in_ready_before_accept", w ? ir64 : ir32, 1'b1);
    if (w) iv64 = 1'b1; else iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; iv64 = 1'b0;
    n = 0;
    while (!ov(w) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    r = w ? res64 : {32'b0, res32};
  endtask

  task automatic consume(input bit w);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", ov(w), 1'b0);
    check("in_ready_after_take", w ? ir64 : ir32, 1'b1);
  endtask

  task automatic watch_quiet(input string nm, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (ov32) seen = 1'b1;
    end
    check(nm, seen, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] r;
    int n;

    vt[0]  = '{F3_MUL,    32'h00000003, 32'h00000002, 32'h00000006, 32};
    vt[1]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32};
    vt[2]  = '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32};
    vt[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32};
    vt[4]  = '{F3_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32};
    vt[5]  = '{F3_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32};
    vt[6]  = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vt[7]  = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0};
    vt[8]  = '{F3_DIVU,   32'h12345678, 32'h00000000, 32'hFFFFFFFF, 0};
    vt[9]  = '{F3_REMU,   32'h12345678, 32'h00000000, 32'h12345678, 0};
    vt[10] = '{F3_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 32};
    vt[11] = '{F3_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 32};
    vt[12] = '{F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32};
    vt[13] = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 32};
    vt[14] = '{F3_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32};
    vt[15] = '{F3_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32};
    vt[16] = '{F3_REM,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 0};
    vt[17] = '{F3_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32};
    vt[18] = '{F3_DIV,    32'h80000000, 32'h00000002, 32'hC0000000, 32};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready32", ir32, 1'b1);
    check("rst_out_valid32", ov32, 1'b0);
    check("rst_result32", res32, 32'h0);
    check("rst_in_ready64", ir64, 1'b1);
    check("rst_out_valid64", ov64, 1'b0);
    check("rst_result64", res64, 64'h0);

    for (int i = 0; i < 19; i++) begin
      run_op(1'b0, vt[i].f, {32'b0, vt[i].a}, {32'b0, vt[i].b}, r, n);
      check($sformatf("vec%0d_result", i), r, {32'b0, vt[i].exp});
      check($sformatf("vec%0d_latency", i), n, vt[i].lat);
      consume(1'b0);
    end

    // flush during the tenth CALC cycle drops the op
    @(negedge clk);
    funct3 = F3_MUL; rs1 = 64'd5; rs2 = 64'd7; iv32 = 1'b1;
    @(posedge clk); #1 iv32 = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_in_ready", ir32, 1'b1);
    check("flush_out_valid", ov32, 1'b0);
    watch_quiet("flush_no_result", 40);

    // flush blocks an accept on the same edge
    @(negedge clk);
    iv32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", ir32, 1'b1);
    watch_quiet("flush_accept_quiet", 40);

    // reset mid-CALC drops the op and clears the result
    @(negedge clk);
    funct3 = F3_DIVU; rs1 = 64'd1000; rs2 = 64'd10; iv32 = 1'b1;
    @(posedge clk); #1 iv32 = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("rst_calc_in_ready", ir32, 1'b1);
    check("rst_calc_out_valid", ov32, 1'b0);
    check("rst_calc_result", res32, 32'h0);
    watch_quiet("rst_calc_no_result", 40);

    // next op completes; result held under back-pressure
    run_op(1'b0, F3_DIVU, 64'd1000, 64'd10, r, n);
    check("after_rst_result", r, 64'd100);
    check("after_rst_latency", n, 32);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_valid", k), ov32, 1'b1);
      check($sformatf("hold%0d_result", k), res32, 32'd100);
    end
    consume(1'b0);

    // reset while in DONE drops the result
    run_op(1'b0, F3_MUL, 64'd9, 64'd9, r, n);
    check("pre_rst_done_result", r, 64'd81);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("rst_done_out_valid", ov32, 1'b0);
    check("rst_done_result", res32, 32'h0);
    watch_quiet("rst_done_quiet", 40);

    // 64-bit instance
    run_op(1'b1, F3_MULHU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, r, n);
    check("x64_mulhu_result", r, 64'hFFFFFFFFFFFFFFFE);
    check("x64_mulhu_latency", n, 64);
    consume(1'b1);
    run_op(1'b1, F3_DIV, 64'hFFFFFFFFFFFFFFF9, 64'd2, r, n);
    check("x64_div_result", r, 64'hFFFFFFFFFFFFFFFD);
    check("x64_div_latency", n, 64);
    consume(1'b1);
    run_op(1'b1, F3_REMU, 64'h0123456789ABCDEF, 64'd0, r, n);
    check("x64_remu_zero_result", r, 64'h0123456789ABCDEF);
    check("x64_remu_zero_latency", n, 0);
    consume(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
